// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between NUM_REQ cache controllers.
// Optional BUSY-cycle timeout abort is compiled in when ARB_TIMEOUT_EN is defined.
module cache_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic                      mem_ready,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]   done_reg, done_next;
  logic                 mem_req_reg, mem_req_next;
  logic                 mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]    mem_addr_reg, mem_addr_next;
  logic [ADDR_W-1:0]    addr_arr [NUM_REQ];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 err_reg, err_next;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_reg;
    for (int o = 0; o < NUM_REQ; o++) begin
      int cand;
      cand = (int'(rr_ptr_reg) + o) % NUM_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    rr_ptr_next   = rr_ptr_reg;
    gnt_next      = gnt_reg;
    done_next     = '0;
    mem_req_next  = mem_req_reg;
    mem_we_next   = mem_we_reg;
    mem_addr_next = mem_addr_reg;
`ifdef ARB_TIMEOUT_EN
    err_next      = 1'b0;
    cnt_next      = cnt_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next        = BUSY;
          idx_next          = win_idx;
          gnt_next          = '0;
          gnt_next[win_idx] = 1'b1;
          mem_req_next      = 1'b1;
          mem_we_next       = req_we[win_idx];
          mem_addr_next     = addr_arr[win_idx];
`ifdef ARB_TIMEOUT_EN
          cnt_next          = '0;
`endif
        end
      end
      BUSY: begin
        // mem_ready takes priority over a timeout on the same edge.
        if (mem_ready) begin
          state_next         = ACK;
          mem_req_next       = 1'b0;
          done_next[idx_reg] = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          state_next         = ACK;
          mem_req_next       = 1'b0;
          done_next[idx_reg] = 1'b1;
          err_next           = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      ACK: begin
        state_next  = IDLE;
        gnt_next    = '0;
        rr_ptr_next = (idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : idx_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      rr_ptr_reg   <= '0;
      gnt_reg      <= '0;
      done_reg     <= '0;
      mem_req_reg  <= 1'b0;
      mem_we_reg   <= 1'b0;
      mem_addr_reg <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      rr_ptr_reg   <= rr_ptr_next;
      gnt_reg      <= gnt_next;
      done_reg     <= done_next;
      mem_req_reg  <= mem_req_next;
      mem_we_reg   <= mem_we_next;
      mem_addr_reg <= mem_addr_next;
`ifdef ARB_TIMEOUT_EN
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
`endif
    end
  end

  assign gnt      = gnt_reg;
  assign done     = done_reg;
  assign mem_req  = mem_req_reg;
  assign mem_we   = mem_we_reg;
  assign mem_addr = mem_addr_reg;
  assign busy     = (state_reg != IDLE);
`ifdef ARB_TIMEOUT_EN
  assign err      = err_reg;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin reference model.
module tb_cache_mem_arbiter;
  localparam int N = 2;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic          mem_ready = 1'b0;
  logic [N-1:0]  gnt, done;
  logic          err, mem_req, mem_we, busy;
  logic [AW-1:0] mem_addr;

  int errors = 0;
  int checks = 0;

  cache_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .mem_ready(mem_ready), .gnt(gnt), .done(done), .err(err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Round-robin rule: first requester at or above ptr, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int o = 0; o < N; o++)
      if (r[(ptr + o) % N]) return (ptr + o) % N;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; req_we = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== '0)     begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    checks++; if (done !== '0)    begin errors++; $display("FAIL reset_done: got %b want 00", done); end
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0)  begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== '0)  begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    $display("test_reset: outputs gnt=%b done=%b busy=%b", gnt, done, busy);
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_addr[0 +: AW] = 24'h123456; req_addr[AW +: AW] = 24'h0badc0; req_we = 2'b10; req = 2'b01;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", gnt); end
    checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_busy: mem_req=%b busy=%b want 1 1", mem_req, busy); end
    checks++; if (mem_addr !== 24'h123456) begin errors++; $display("FAIL single_addr: got %h want 123456", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we: got %b want 0", mem_we); end
    @(negedge clk);
    checks++; if (done !== 2'b00 || mem_req !== 1'b1) begin errors++; $display("FAIL single_wait: done=%b mem_req=%b want 00 1", done, mem_req); end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (done !== 2'b01 || mem_req !== 1'b0 || gnt !== 2'b01) begin
      errors++; $display("FAIL single_done: done=%b mem_req=%b gnt=%b want 01 0 01", done, mem_req, gnt); end
    req = '0; mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (done !== 2'b00 || busy !== 1'b0 || gnt !== 2'b00) begin
      errors++; $display("FAIL single_idle: done=%b busy=%b gnt=%b want 00 0 00", done, busy, gnt); end
    $display("test_single: addr=%h we=%b", mem_addr, mem_we);
  endtask

  task automatic test_contention();
    int order[$];
    logic [N-1:0] last_gnt;
    do_reset();
    req_addr[0 +: AW] = 24'h222222; req_addr[AW +: AW] = 24'h333333; req_we = 2'b10;
    req = 2'b11; mem_ready = 1'b1; last_gnt = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++; if ((gnt & (gnt - 1'b1)) !== '0) begin errors++; $display("FAIL contention_onehot: gnt=%b", gnt); end
      if (gnt != '0 && last_gnt == '0) begin
        int w;
        w = (gnt == 2'b01) ? 0 : 1;
        order.push_back(w);
        checks++; if (mem_addr !== req_addr[w*AW +: AW] || mem_we !== req_we[w]) begin
          errors++; $display("FAIL contention_latch: req%0d addr=%h we=%b want %h %b", w, mem_addr, mem_we, req_addr[w*AW +: AW], req_we[w]); end
      end
      req = req & ~done;
      last_gnt = gnt;
    end
    checks++; if (order.size() != 2) begin errors++; $display("FAIL contention_count: got %0d grants want 2", order.size()); end
    else begin
      checks++; if (order[0] != 0 || order[1] != 1) begin errors++; $display("FAIL contention_order: got %0d,%0d want 0,1", order[0], order[1]); end
    end
    req = 2'b11;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL contention_rr_wrap: got %b want 01", gnt); end
    $display("test_contention: %0d grants, rr restart gnt=%b", order.size(), gnt);
  endtask

  task automatic test_fairness();
    int order[$];
    logic [N-1:0] last_gnt;
    do_reset();
    req = 2'b11; mem_ready = 1'b1; last_gnt = '0;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      @(negedge clk);
      if (gnt != '0 && last_gnt == '0) order.push_back(gnt == 2'b01 ? 0 : 1);
      last_gnt = gnt;
      if (done[1]) req[1] = 1'b0;
      else req[1] = 1'b1;
    end
    checks++; if (order.size() != 4) begin errors++; $display("FAIL fairness_count: got %0d grants want 4", order.size()); end
    for (int i = 0; i < order.size(); i++) begin
      checks++; if (order[i] != i % 2) begin errors++; $display("FAIL fairness_order: grant %0d got req%0d want req%0d", i, order[i], i % 2); end
    end
    $display("test_fairness: %0d grants observed", order.size());
  endtask

  task automatic test_zero_wait();
    do_reset();
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (done !== '0 || busy !== 1'b0) begin errors++; $display("FAIL zero_wait_idle: done=%b busy=%b want 00 0", done, busy); end
    end
    for (int r = N - 1; r >= 0; r--) begin
      req = '0; req[r] = 1'b1;
      @(negedge clk);
      checks++; if (done !== '0) begin errors++; $display("FAIL zero_wait_early: req%0d done=%b want 00", r, done); end
      @(negedge clk);
      checks++; if (done !== (2'b01 << r)) begin errors++; $display("FAIL zero_wait_done: req%0d done=%b want %b", r, done, 2'b01 << r); end
      req = '0;
      @(negedge clk);
      checks++; if (done !== '0) begin errors++; $display("FAIL zero_wait_pulse: req%0d done=%b want 00", r, done); end
      $display("test_zero_wait: req%0d completed", r);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req_addr[0 +: AW] = 24'habcdef; req_we = 2'b01; req = 2'b01; mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL midrst_setup: mem_req=%b want 1", mem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({gnt, done, err, mem_req, mem_we, busy} !== '0 || mem_addr !== '0) begin
      errors++; $display("FAIL midrst_async: gnt=%b done=%b err=%b mem_req=%b mem_we=%b busy=%b addr=%h want all 0",
                         gnt, done, err, mem_req, mem_we, busy, mem_addr); end
    req = '0; mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (done !== '0) begin errors++; $display("FAIL midrst_no_done: done=%b want 00", done); end
    end
    req = 2'b10;
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL midrst_next_gnt: got %b want 10", gnt); end
    $display("test_reset_mid_busy: next grant gnt=%b", gnt);
  endtask

  task automatic test_timeout();
    do_reset();
    req = 2'b01; mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_entry: busy=%b want 1", busy); end
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 65; i++) begin
      @(negedge clk);
      if (i < 64) begin
        if (err !== 1'b0 || done !== '0) begin
          checks++; errors++; $display("FAIL timeout_early: cycle %0d err=%b done=%b want 0 00", i, err, done); end
      end else if (i == 64) begin
        checks++; if (err !== 1'b1 || done !== 2'b01 || mem_req !== 1'b0) begin
          errors++; $display("FAIL timeout_abort: err=%b done=%b mem_req=%b want 1 01 0", err, done, mem_req); end
        req = '0;
      end else begin
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_after: err=%b busy=%b want 0 0", err, busy); end
      end
    end
    $display("test_timeout: abort path exercised");
`else
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || err !== 1'b0 || done !== '0) begin
        checks++; errors++; $display("FAIL timeout_wait: cycle %0d busy=%b err=%b done=%b want 1 0 00", i, busy, err, done); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_still_busy: busy=%b want 1", busy); end
    $display("test_timeout: still waiting after 100 cycles");
`endif
  endtask

  // Randomized traffic against a protocol-level model: phase 0 idle, 1 access open, 2 completion.
  task automatic test_random();
    int phase = 0, active = -1, model_rr = 0, txns = 0;
    logic [AW-1:0] exp_addr [N];
    logic          exp_we   [N];
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++; if ((gnt & (gnt - 1'b1)) !== '0) begin errors++; $display("FAIL random_onehot: cycle %0d gnt=%b", c, gnt); end
      case (phase)
        0: begin
          if (req != '0) begin
            active = rr_pick(req, model_rr);
            checks++;
            if (gnt !== (2'b01 << active) || mem_req !== 1'b1 || mem_addr !== exp_addr[active] || mem_we !== exp_we[active]) begin
              errors++; $display("FAIL random_grant: cycle %0d gnt=%b mem_req=%b addr=%h we=%b want %b 1 %h %b",
                                 c, gnt, mem_req, mem_addr, mem_we, 2'b01 << active, exp_addr[active], exp_we[active]);
            end
            phase = 1;
            // Address/we changes after the latch must not reach the memory port.
            req_addr[active*AW +: AW] = AW'($urandom());
            req_we[active] = 1'($urandom());
          end else begin
            checks++; if (gnt !== '0 || busy !== 1'b0 || done !== '0) begin
              errors++; $display("FAIL random_idle: cycle %0d gnt=%b busy=%b done=%b want 00 0 00", c, gnt, busy, done); end
          end
        end
        1: begin
          if (mem_ready) begin
            checks++; if (done !== (2'b01 << active) || mem_req !== 1'b0) begin
              errors++; $display("FAIL random_done: cycle %0d done=%b mem_req=%b want %b 0", c, done, mem_req, 2'b01 << active); end
            phase = 2;
            req[active] = 1'b0;
            txns++;
          end else begin
            checks++; if (done !== '0 || mem_req !== 1'b1 || mem_addr !== exp_addr[active] || gnt !== (2'b01 << active)) begin
              errors++; $display("FAIL random_hold: cycle %0d done=%b mem_req=%b addr=%h gnt=%b want 00 1 %h %b",
                                 c, done, mem_req, mem_addr, gnt, exp_addr[active], 2'b01 << active); end
          end
        end
        default: begin
          checks++; if (gnt !== '0 || busy !== 1'b0 || done !== '0) begin
            errors++; $display("FAIL random_release: cycle %0d gnt=%b busy=%b done=%b want 00 0 00", c, gnt, busy, done); end
          model_rr = (active + 1) % N;
          active = -1;
          phase = 0;
        end
      endcase
      mem_ready = ($urandom_range(0, 9) < 3);
      for (int i = 0; i < N; i++) begin
        if (!req[i] && i != active && $urandom_range(0, 9) < 3) begin
          exp_addr[i] = AW'($urandom());
          exp_we[i] = 1'($urandom());
          req_addr[i*AW +: AW] = exp_addr[i];
          req_we[i] = exp_we[i];
          req[i] = 1'b1;
        end
      end
    end
    checks++; if (txns < 100) begin errors++; $display("FAIL random_throughput: got %0d transactions want >=100", txns); end
    $display("test_random: %0d transactions completed", txns);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_zero_wait();
    test_reset_mid_busy();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
